// File: rtl/mem_bridge_ctrl.sv
// Two-port round-robin sequencer for the MainBus/MemData memory bridge.
// Every output is a register, so the bridge and memory enables never glitch.
module mem_bridge_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              done1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              a_membridge_n,
  output logic              d_membridge_n
);

  typedef enum logic [2:0] {
    IDLE, RD_ACC, RD_DRV, WR_SET, WR_PLS, WR_HLD, TURN
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t     state;
  logic [3:0] waitCnt;
  logic       lastGrant;
  logic       grantPort;
  logic       pickPort;
  logic       pickWrite;

  // On a tie the port that was not served last wins; otherwise whoever asks.
  assign pickPort  = (req0 && req1) ? ~lastGrant : req1;
  assign pickWrite = pickPort ? we1 : we0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      waitCnt       <= 4'd0;
      lastGrant     <= 1'b1;
      grantPort     <= 1'b0;
      done0         <= 1'b0;
      done1         <= 1'b0;
      busy          <= 1'b0;
      mem_addr      <= '0;
      mem_oe_n      <= 1'b1;
      mem_we_n      <= 1'b1;
      a_membridge_n <= 1'b1;
      d_membridge_n <= 1'b1;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grantPort <= pickPort;
            lastGrant <= pickPort;
            mem_addr  <= pickPort ? addr1 : addr0;
            busy      <= 1'b1;
            if (pickWrite) begin
              state         <= WR_SET;
              d_membridge_n <= 1'b0;
            end else begin
              state    <= RD_ACC;
              mem_oe_n <= 1'b0;
              waitCnt  <= WAIT_LOAD;
            end
          end
        end
        RD_ACC: begin
          if (waitCnt == 4'd0) begin
            state         <= RD_DRV;
            a_membridge_n <= 1'b0;
            done0         <= ~grantPort;
            done1         <= grantPort;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RD_DRV: begin
          state         <= TURN;
          mem_oe_n      <= 1'b1;
          a_membridge_n <= 1'b1;
        end
        WR_SET: begin
          state    <= WR_PLS;
          mem_we_n <= 1'b0;
          waitCnt  <= WAIT_LOAD;
        end
        WR_PLS: begin
          if (waitCnt == 4'd0) begin
            state    <= WR_HLD;
            mem_we_n <= 1'b1;
            done0    <= ~grantPort;
            done1    <= grantPort;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        WR_HLD: begin
          state         <= TURN;
          d_membridge_n <= 1'b1;
        end
        TURN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          mem_oe_n      <= 1'b1;
          mem_we_n      <= 1'b1;
          a_membridge_n <= 1'b1;
          d_membridge_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge_ctrl.sv
// Directed bench for mem_bridge_ctrl (WAIT_STATES=1): per-scenario tasks with
// inline expectations; per-cycle activity is tallied for the invariant checks.
module tb_mem_bridge_ctrl;
  localparam int ADDR_W = 16;
  localparam int WS     = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              done0, done1, busy, mem_oe_n, mem_we_n, a_membridge_n, d_membridge_n;
  logic [ADDR_W-1:0] mem_addr;

  mem_bridge_ctrl #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .done1(done1),
    .busy(busy), .mem_addr(mem_addr), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .a_membridge_n(a_membridge_n), .d_membridge_n(d_membridge_n)
  );

  int checks = 0;
  int failures = 0;

  int gcyc = 0;
  int oeLow, weLow, aLow, dLow, d0Cnt, d1Cnt, coinc, invBad;
  int oeFirst, weFirst, weLast, dFirst, dLast, lastA, doneAt;
  logic [ADDR_W-1:0] addrAtDone, prevAddr;
  logic prevBusy = 1'b0;

  task automatic clear_stats();
    oeLow = 0; weLow = 0; aLow = 0; dLow = 0; d0Cnt = 0; d1Cnt = 0;
    coinc = 0; invBad = 0; oeFirst = -1; weFirst = -1; weLast = -1;
    dFirst = -1; dLast = -1; lastA = -1; doneAt = -1; addrAtDone = '0;
  endtask

  // Advance one cycle and tally what the outputs did (no judgement here).
  task automatic sample_cycle();
    @(posedge clk);
    #1;
    gcyc++;
    if (!mem_oe_n) begin oeLow++; if (oeFirst < 0) oeFirst = gcyc; end
    if (!mem_we_n) begin weLow++; if (weFirst < 0) weFirst = gcyc; weLast = gcyc; end
    if (!a_membridge_n) begin aLow++; lastA = gcyc; if (done0 || done1) coinc++; end
    if (!d_membridge_n) begin dLow++; if (dFirst < 0) dFirst = gcyc; dLast = gcyc; end
    if (done0) begin d0Cnt++; doneAt = gcyc; addrAtDone = mem_addr; end
    if (done1) begin d1Cnt++; doneAt = gcyc; addrAtDone = mem_addr; end
    if ((!a_membridge_n && !d_membridge_n) || (!mem_oe_n && !mem_we_n) ||
        (!a_membridge_n && mem_oe_n) || (!mem_we_n && d_membridge_n) || (done0 && done1))
      invBad++;
    if (busy && prevBusy && (mem_addr !== prevAddr)) invBad++;
    prevBusy = busy;
    prevAddr = mem_addr;
  endtask

  // Issue one request, hold it until its done (bounded), then drain TURN/IDLE.
  task automatic do_transfer(input bit p, input bit w, input logic [ADDR_W-1:0] a,
                             output int startCyc);
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; end
    clear_stats();
    startCyc = gcyc;
    for (int i = 0; i < 40; i++) begin
      sample_cycle();
      if (p ? done1 : done0) break;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    sample_cycle();
    sample_cycle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 16'h1234;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0;
    for (int i = 0; i < 3; i++) begin
      sample_cycle();
      checks++;
      if ({done0, done1, busy, mem_oe_n, mem_we_n, a_membridge_n, d_membridge_n} !== 7'b0001111 ||
          mem_addr !== 16'h0000) begin
        failures++;
        $display("FAIL reset_values cycle=%0d got=%b addr=%h exp=0001111 addr=0000", i,
                 {done0, done1, busy, mem_oe_n, mem_we_n, a_membridge_n, d_membridge_n}, mem_addr);
      end
    end
    req0 = 1'b0;
    reset_n = 1'b1;
    sample_cycle();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_read();
    int s;
    do_transfer(1'b0, 1'b0, 16'h1234, s);
    checks++; if (oeLow != 3) begin failures++; $display("FAIL rd_oe_low got=%0d exp=3", oeLow); end
    checks++; if (oeFirst - s != 1) begin failures++; $display("FAIL rd_oe_start got=%0d exp=1", oeFirst - s); end
    checks++; if (aLow != 1) begin failures++; $display("FAIL rd_a_low got=%0d exp=1", aLow); end
    checks++; if (coinc != 1) begin failures++; $display("FAIL rd_a_with_done got=%0d exp=1", coinc); end
    checks++; if (doneAt - s != 3) begin failures++; $display("FAIL rd_done_latency got=%0d exp=3", doneAt - s); end
    checks++; if (d0Cnt != 1 || d1Cnt != 0) begin failures++; $display("FAIL rd_done_counts got=%0d/%0d exp=1/0", d0Cnt, d1Cnt); end
    checks++; if (dLow != 0 || weLow != 0) begin failures++; $display("FAIL rd_write_side got=%0d/%0d exp=0/0", dLow, weLow); end
    checks++; if (addrAtDone !== 16'h1234) begin failures++; $display("FAIL rd_addr got=%h exp=1234", addrAtDone); end
    checks++; if (invBad != 0) begin failures++; $display("FAIL rd_invariants got=%0d exp=0", invBad); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write();
    int s;
    do_transfer(1'b1, 1'b1, 16'h00AA, s);
    checks++; if (dLow != 4) begin failures++; $display("FAIL wr_d_low got=%0d exp=4", dLow); end
    checks++; if (dFirst - s != 1) begin failures++; $display("FAIL wr_d_start got=%0d exp=1", dFirst - s); end
    checks++; if (weLow != 2) begin failures++; $display("FAIL wr_we_low got=%0d exp=2", weLow); end
    checks++; if (weFirst - dFirst != 1 || dLast - weLast != 1) begin
      failures++; $display("FAIL wr_we_inside got=%0d/%0d exp=1/1", weFirst - dFirst, dLast - weLast); end
    checks++; if (d1Cnt != 1 || d0Cnt != 0 || doneAt != dLast) begin
      failures++; $display("FAIL wr_done got=%0d/%0d at=%0d exp=1/0 at=%0d", d1Cnt, d0Cnt, doneAt, dLast); end
    checks++; if (aLow != 0 || oeLow != 0) begin failures++; $display("FAIL wr_read_side got=%0d/%0d exp=0/0", aLow, oeLow); end
    checks++; if (addrAtDone !== 16'h00AA) begin failures++; $display("FAIL wr_addr got=%h exp=00aa", addrAtDone); end
    checks++; if (invBad != 0) begin failures++; $display("FAIL wr_invariants got=%0d exp=0", invBad); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] order;
    logic [ADDR_W-1:0] addrs [4];
    int n, turnBad;
    bit reassert;
    clear_stats();
    order = 4'b0; n = 0; turnBad = 0; reassert = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h1000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h2000;
    for (int i = 0; i < 80 && n < 4; i++) begin
      sample_cycle();
      if (reassert) begin
        if (!(a_membridge_n && d_membridge_n && busy)) turnBad++;
        req0 = 1'b1; req1 = 1'b1; reassert = 1'b0;
      end
      if (done0 || done1) begin
        order[n] = done1;
        addrs[n] = mem_addr;
        n++;
        if (done0) req0 = 1'b0; else req1 = 1'b0;
        reassert = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    sample_cycle();
    sample_cycle();
    checks++; if (n != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", n); end
    checks++; if (order !== 4'b1010) begin failures++; $display("FAIL b2b_order got=%b exp=1010 (lsb first)", order); end
    checks++; if (addrs[0] !== 16'h1000 || addrs[1] !== 16'h2000 || addrs[2] !== 16'h1000 || addrs[3] !== 16'h2000) begin
      failures++; $display("FAIL b2b_addr got=%h %h %h %h exp=1000 2000 1000 2000", addrs[0], addrs[1], addrs[2], addrs[3]); end
    checks++; if (turnBad != 0) begin failures++; $display("FAIL b2b_turn got=%0d exp=0", turnBad); end
    checks++; if (invBad != 0) begin failures++; $display("FAIL b2b_invariants got=%0d exp=0", invBad); end
  endtask

  task automatic test_read_then_write();
    int nDone;
    clear_stats();
    nDone = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0055;
    for (int i = 0; i < 40 && nDone < 2; i++) begin
      sample_cycle();
      if (done0) begin nDone++; we0 = 1'b1; end
    end
    req0 = 1'b0;
    sample_cycle();
    sample_cycle();
    checks++; if (d0Cnt != 2) begin failures++; $display("FAIL rw_done_count got=%0d exp=2", d0Cnt); end
    checks++; if (dFirst - lastA != 3) begin failures++; $display("FAIL rw_turnaround got=%0d exp=3", dFirst - lastA); end
    checks++; if (aLow != 1 || dLow != 4) begin failures++; $display("FAIL rw_enables got=%0d/%0d exp=1/4", aLow, dLow); end
    checks++; if (invBad != 0) begin failures++; $display("FAIL rw_invariants got=%0d exp=0", invBad); end
  endtask

  task automatic test_reset_mid_write();
    int firstPort;
    clear_stats();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0BEE;
    for (int i = 0; i < 20; i++) begin
      sample_cycle();
      if (!mem_we_n) break;
    end
    checks++; if (weLow != 1) begin failures++; $display("FAIL rst_reach_pulse got=%0d exp=1", weLow); end
    reset_n = 1'b0;
    req0 = 1'b0;
    sample_cycle();
    checks++;
    if ({mem_we_n, d_membridge_n, busy, done0} !== 4'b1100 || mem_addr !== 16'h0000) begin
      failures++; $display("FAIL rst_abort got=%b addr=%h exp=1100 addr=0000", {mem_we_n, d_membridge_n, busy, done0}, mem_addr);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) sample_cycle();
    checks++; if (d0Cnt != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", d0Cnt); end
    // Port 0 was granted last before the reset, so port 0 winning proves the pointer was reset.
    clear_stats();
    firstPort = -1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0300;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0400;
    for (int i = 0; i < 40 && d1Cnt == 0; i++) begin
      sample_cycle();
      if (done0) begin if (firstPort < 0) firstPort = 0; req0 = 1'b0; end
      if (done1) begin if (firstPort < 0) firstPort = 1; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    sample_cycle();
    sample_cycle();
    checks++; if (firstPort != 0) begin failures++; $display("FAIL rst_pointer got=%0d exp=0", firstPort); end
    checks++; if (d0Cnt != 1 || d1Cnt != 1) begin failures++; $display("FAIL rst_resume got=%0d/%0d exp=1/1", d0Cnt, d1Cnt); end
    checks++; if (invBad != 0) begin failures++; $display("FAIL rst_invariants got=%0d exp=0", invBad); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_read_then_write();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
